// File: rtl/apb_cmd_arbiter_if.sv
// Command-port bundle between NUM_REQ requesters, the arbiter and apb_top.
interface apb_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        write_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ*STRB_W-1:0] strb_i;
  logic [NUM_REQ*3-1:0]      prot_i;
  logic [NUM_REQ-1:0]        ack_o;
  logic [DATA_W-1:0]         rdata_o;
  logic                      error_o;
  logic                      busy_o;
  logic [IDX_W-1:0]          gnt_idx_o;

  // apb_top command side
  logic                      start;
  logic                      write;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wdata;
  logic [STRB_W-1:0]         strb;
  logic [2:0]                prot;
  logic [DATA_W-1:0]         rdata;
  logic                      done;
  logic                      error;

  // arbiter view
  modport slave (
    input  req_i, write_i, addr_i, wdata_i, strb_i, prot_i, rdata, done, error,
    output ack_o, rdata_o, error_o, busy_o, gnt_idx_o,
    output start, write, addr, wdata, strb, prot
  );

  // requesters plus apb_top view
  modport master (
    output req_i, write_i, addr_i, wdata_i, strb_i, prot_i, rdata, done, error,
    input  ack_o, rdata_o, error_o, busy_o, gnt_idx_o,
    input  start, write, addr, wdata, strb, prot
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Round-robin sharing of the apb_top command port among NUM_REQ requesters.
// One transfer at a time: IDLE -> ISSUE -> WAIT -> RESP -> DRAIN -> IDLE.
module apb_cmd_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input logic              pclk,
  input logic              presetn,
  apb_cmd_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    rr, rr_d;
  logic [IDX_W-1:0]    gnt_d;
  logic [IDX_W-1:0]    win_idx, cand;
  logic                win_found;
  logic [NUM_REQ-1:0]  ack_d;
  logic                start_d, busy_d, write_d, error_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic [STRB_W-1:0]   strb_d;
  logic [2:0]          prot_d;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [STRB_W-1:0]   strb_arr  [NUM_REQ];
  logic [2:0]          prot_arr  [NUM_REQ];

  // Unflatten the per-requester command fields.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign addr_arr[g]  = bus.addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.wdata_i[g*DATA_W +: DATA_W];
    assign strb_arr[g]  = bus.strb_i[g*STRB_W +: STRB_W];
    assign prot_arr[g]  = bus.prot_i[g*3 +: 3];
  end

  // First requesting slot at or after the rr pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr) + i) % NUM_REQ);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state;
    rr_d    = rr;
    gnt_d   = bus.gnt_idx_o;
    start_d = 1'b0;
    ack_d   = '0;
    write_d = bus.write;
    addr_d  = bus.addr;
    wdata_d = bus.wdata;
    strb_d  = bus.strb;
    prot_d  = bus.prot;
    rdata_d = bus.rdata_o;
    error_d = bus.error_o;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = ISSUE;
          gnt_d   = win_idx;
          start_d = 1'b1;
          write_d = bus.write_i[win_idx];
          addr_d  = addr_arr[win_idx];
          wdata_d = wdata_arr[win_idx];
          strb_d  = strb_arr[win_idx];
          prot_d  = prot_arr[win_idx];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.done) begin
          state_d = RESP;
          rdata_d = bus.rdata;
          error_d = bus.error;
          ack_d   = NUM_REQ'(1) << bus.gnt_idx_o;
        end
      end
      RESP: begin
        state_d = DRAIN;
        rr_d    = IDX_W'((32'(bus.gnt_idx_o) + 1) % NUM_REQ);
      end
      // Hold off until a level-style done has dropped.
      DRAIN: begin
        if (!bus.done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, rr pointer and registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= IDLE;
      rr            <= '0;
      bus.gnt_idx_o <= '0;
      bus.start     <= 1'b0;
      bus.ack_o     <= '0;
      bus.busy_o    <= 1'b0;
      bus.write     <= 1'b0;
      bus.addr      <= '0;
      bus.wdata     <= '0;
      bus.strb      <= '0;
      bus.prot      <= '0;
      bus.rdata_o   <= '0;
      bus.error_o   <= 1'b0;
    end else begin
      state         <= state_d;
      rr            <= rr_d;
      bus.gnt_idx_o <= gnt_d;
      bus.start     <= start_d;
      bus.ack_o     <= ack_d;
      bus.busy_o    <= busy_d;
      bus.write     <= write_d;
      bus.addr      <= addr_d;
      bus.wdata     <= wdata_d;
      bus.strb      <= strb_d;
      bus.prot      <= prot_d;
      bus.rdata_o   <= rdata_d;
      bus.error_o   <= error_d;
    end
  end
endmodule
